// File: rtl/ysyx_23060278_lut_reverse_search_pkg.sv
// Shared definitions for the LUT reverse-search block: FSM state encoding and
// the index-width helper used to size the table pointer.
package ysyx_23060278_lut_reverse_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Keep at least one index bit so degenerate tables still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_23060278_lut_reverse_search_table.sv
// Entry register bank for the reverse-search LUT: one write port, bulk clear,
// and an asynchronous read of the entry currently being scanned.
module ysyx_23060278_lut_table #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 32,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  output logic [KEY_LEN-1:0]  rd_key,
  output logic [DATA_LEN-1:0] rd_data
);

  logic                entry_valid [NR_KEY];
  logic [KEY_LEN-1:0]  entry_key   [NR_KEY];
  logic [DATA_LEN-1:0] entry_data  [NR_KEY];

  generate
    for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
      logic                sel;
      logic                valid_reg;
      logic [KEY_LEN-1:0]  key_reg;
      logic [DATA_LEN-1:0] data_reg;

      // Out-of-range indices match no entry and are silently dropped.
      assign sel = wr_en && (wr_idx == IDX_W'(gi));

      // A write in the same cycle as clr wins, leaving the entry valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          key_reg   <= '0;
          data_reg  <= '0;
        end else if (sel) begin
          valid_reg <= 1'b1;
          key_reg   <= wr_key;
          data_reg  <= wr_data;
        end else if (clr) begin
          valid_reg <= 1'b0;
        end
      end

      assign entry_valid[gi] = valid_reg;
      assign entry_key[gi]   = key_reg;
      assign entry_data[gi]  = data_reg;
    end
  endgenerate

  assign rd_valid = entry_valid[rd_idx];
  assign rd_key   = entry_key[rd_idx];
  assign rd_data  = entry_data[rd_idx];

endmodule

// File: rtl/ysyx_23060278_lut_reverse_search.sv
// Sequential reverse lookup (data -> key) over a writable LUT, one entry per cycle.
// Define YSYX_23060278_LUT_MULTI_HIT_EN to always scan the full table and flag multiple hits.
module ysyx_23060278_lut_reverse_search
  import ysyx_23060278_lut_reverse_search_pkg::*;
#(
  parameter int  NR_KEY   = 4,
  parameter int  KEY_LEN  = 4,
  parameter int  DATA_LEN = 32,
  localparam int IDX_W    = idx_width(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic [KEY_LEN-1:0]  default_key,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic [KEY_LEN-1:0]  resp_key,
  output logic [IDX_W-1:0]    resp_idx,
  output logic                resp_multi
);

  state_e              state_reg, state_next;
  logic [IDX_W-1:0]    ptr_reg;
  logic [DATA_LEN-1:0] req_data_reg;
  logic                hit_reg;
  logic [KEY_LEN-1:0]  key_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                rd_valid;
  logic [KEY_LEN-1:0]  rd_key;
  logic [DATA_LEN-1:0] rd_data;
  logic                match;
  logic                last;

  ysyx_23060278_lut_table #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .DATA_LEN(DATA_LEN),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_key  (wr_key),
    .wr_data (wr_data),
    .clr     (clr),
    .rd_idx  (ptr_reg),
    .rd_valid(rd_valid),
    .rd_key  (rd_key),
    .rd_data (rd_data)
  );

  assign match = rd_valid && (rd_data == req_data_reg);
  assign last  = (ptr_reg == IDX_W'(NR_KEY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_valid) state_next = ST_SCAN;
`ifdef YSYX_23060278_LUT_MULTI_HIT_EN
      ST_SCAN: if (last) state_next = ST_RESP;
`else
      ST_SCAN: if (match || last) state_next = ST_RESP;
`endif
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_reg == ST_IDLE);
    resp_valid = (state_reg == ST_RESP);
  end

`ifdef YSYX_23060278_LUT_MULTI_HIT_EN
  logic multi_reg;

  // Full scan: the first hit fixes key/idx, any later hit only raises multi.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= '0;
      req_data_reg <= '0;
      hit_reg      <= 1'b0;
      key_reg      <= '0;
      idx_reg      <= '0;
      multi_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (req_valid) begin
          req_data_reg <= req_data;
          ptr_reg      <= '0;
          hit_reg      <= 1'b0;
          multi_reg    <= 1'b0;
        end
        ST_SCAN: begin
          ptr_reg <= ptr_reg + IDX_W'(1);
          if (match) begin
            if (!hit_reg) begin
              hit_reg <= 1'b1;
              key_reg <= rd_key;
              idx_reg <= ptr_reg;
            end else begin
              multi_reg <= 1'b1;
            end
          end else if (last && !hit_reg) begin
            key_reg <= default_key;
            idx_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_multi = multi_reg;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= '0;
      req_data_reg <= '0;
      hit_reg      <= 1'b0;
      key_reg      <= '0;
      idx_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (req_valid) begin
          req_data_reg <= req_data;
          ptr_reg      <= '0;
          hit_reg      <= 1'b0;
        end
        ST_SCAN: begin
          ptr_reg <= ptr_reg + IDX_W'(1);
          if (match) begin
            hit_reg <= 1'b1;
            key_reg <= rd_key;
            idx_reg <= ptr_reg;
          end else if (last) begin
            key_reg <= default_key;
            idx_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_multi = 1'b0;
`endif

  assign resp_hit = hit_reg;
  assign resp_key = key_reg;
  assign resp_idx = idx_reg;

endmodule

// File: tb/tb_ysyx_23060278_lut_reverse_search.sv
// Scoreboard bench for the LUT reverse search: a table model predicts each response,
// a negedge monitor checks fields, latency and handshake behaviour.
module tb_ysyx_23060278_lut_reverse_search;

  localparam int NR_KEY   = 4;
  localparam int KEY_LEN  = 4;
  localparam int DATA_LEN = 32;
  localparam int IDX_W    = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                wr_en = 1'b0;
  logic [IDX_W-1:0]    wr_idx = '0;
  logic [KEY_LEN-1:0]  wr_key = '0;
  logic [DATA_LEN-1:0] wr_data = '0;
  logic                clr = 1'b0;
  logic [KEY_LEN-1:0]  default_key = 4'hF;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [DATA_LEN-1:0] req_data = '0;
  logic                resp_valid;
  logic                resp_ready = 1'b1;
  logic                resp_hit;
  logic [KEY_LEN-1:0]  resp_key;
  logic [IDX_W-1:0]    resp_idx;
  logic                resp_multi;

  ysyx_23060278_lut_reverse_search #(
    .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .default_key(default_key),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_key(resp_key), .resp_idx(resp_idx), .resp_multi(resp_multi)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_LEN-1:0] data;
    logic                hit;
    logic [KEY_LEN-1:0]  key;
    logic [IDX_W-1:0]    idx;
    logic                multi;
    int                  lat;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned acc_q[$];
  bit          in_resp = 0;

  bit                  m_valid [NR_KEY];
  logic [KEY_LEN-1:0]  m_key   [NR_KEY];
  logic [DATA_LEN-1:0] m_data  [NR_KEY];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", name, cyc);
  endtask

  // Reference: lowest valid index holding d wins; latency from the scan rules.
  function automatic exp_t model(input logic [DATA_LEN-1:0] d);
    exp_t e;
    int   n = 0;
    e.data = d; e.hit = 1'b0; e.key = default_key; e.idx = '0; e.multi = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (m_valid[i] && m_data[i] == d) begin
        n++;
        e.hit = 1'b1; e.key = m_key[i]; e.idx = IDX_W'(i);
      end
    end
`ifdef YSYX_23060278_LUT_MULTI_HIT_EN
    e.multi = (n >= 2);
    e.lat   = NR_KEY + 1;
`else
    e.lat   = e.hit ? int'(e.idx) + 2 : NR_KEY + 1;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR_KEY; i++) m_valid[i] = 1'b0;
  endtask

  task automatic write(input int idx, input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] d, input bit with_clr);
    wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_key = k; wr_data = d; clr = with_clr;
    tick();
    wr_en = 1'b0; clr = 1'b0;
    if (with_clr) model_clear();
    m_valid[idx] = 1'b1; m_key[idx] = k; m_data[idx] = d;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
  endtask

  task automatic issue(input logic [DATA_LEN-1:0] d, input bit track);
    int n = 0;
    req_valid = 1'b1; req_data = d;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) timeout("req_ready_wait");
    if (track) exp_q.push_back(model(d));
    tick();
    req_valid = 1'b0; req_data = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && !resp_valid) && n < 60) begin tick(); n++; end
    if (n >= 60) timeout("idle_wait");
  endtask

  task automatic search(input logic [DATA_LEN-1:0] d, input int stall);
    int n = 0;
    resp_ready = (stall == 0);
    issue(d, 1'b1);
    if (stall > 0) begin
      while (!resp_valid && n < 40) begin tick(); n++; end
      if (!resp_valid) timeout("resp_valid_wait");
      repeat (stall) tick();
      resp_ready = 1'b1;
      tick();
      chk("idle_after_accept", req_ready, 1);
    end
    wait_idle();
  endtask

  function automatic logic [DATA_LEN-1:0] pool_data();
    case ($urandom_range(0, 4))
      0: return 32'h11;
      1: return 32'h22;
      2: return 32'h55;
      3: return 32'h99;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compares every presented response cycle against the queue head.
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      in_resp = 0;
    end else begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (resp_valid) begin
        chk("req_ready_in_resp", req_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", resp_valid, 0);
        end else begin
          if (!in_resp) begin
            in_resp = 1;
            if (acc_q.size() == 0) chk("resp_without_accept", resp_valid, 0);
            else chk("latency", cyc - acc_q.pop_front(), exp_q[0].lat);
          end
          chk("resp_hit", resp_hit, exp_q[0].hit);
          chk("resp_key", resp_key, exp_q[0].key);
          chk("resp_idx", resp_idx, exp_q[0].idx);
          chk("resp_multi", resp_multi, exp_q[0].multi);
          if (resp_ready) begin
            $display("resp data=%08h hit=%0d key=%0h idx=%0d multi=%0d", exp_q[0].data,
                     resp_hit, resp_key, resp_idx, resp_multi);
            void'(exp_q.pop_front());
            in_resp = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_hit", resp_hit, 0);
    chk("reset_resp_key", resp_key, 0);
    chk("reset_resp_idx", resp_idx, 0);
    chk("reset_resp_multi", resp_multi, 0);

    // Empty table: miss returns default key after a full scan.
    search(32'h0, 0);

    write(0, 4'h3, 32'h11, 1'b0);
    write(2, 4'h7, 32'h22, 1'b0);
    search(32'h22, 0);
    search(32'h11, 0);

    // Duplicate data: lowest index wins.
    write(1, 4'hA, 32'h55, 1'b0);
    write(3, 4'hB, 32'h55, 1'b0);
    search(32'h55, 0);

    // Back-pressure: response held for three cycles.
    search(32'h55, 3);

    // Overwrite entry 2 in the very cycle it is compared.
    issue(32'h22, 1'b1);
    tick();
    tick();
    write(2, 4'h7, 32'h99, 1'b0);
    wait_idle();
    search(32'h22, 0);
    search(32'h99, 0);

    // Reset during scan drops the response and clears the table.
    issue(32'h11, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_midscan_req_ready", req_ready, 1);
    chk("rst_midscan_resp_valid", resp_valid, 0);
    tick();
    rst = 1'b0;
    model_clear();
    repeat (2) tick();
    search(32'h11, 0);
    search(32'h55, 0);

    // clr invalidates; a write in the same cycle still lands.
    write(0, 4'h3, 32'h11, 1'b0);
    write(2, 4'h5, 32'h33, 1'b0);
    do_clr();
    search(32'h11, 0);
    write(1, 4'h9, 32'h77, 1'b1);
    write(3, 4'h4, 32'h66, 1'b0);
    search(32'h33, 0);
    search(32'h77, 0);

    for (int it = 0; it < 60; it++) begin
      default_key = KEY_LEN'($urandom);
      case ($urandom_range(0, 5))
        0, 1: write($urandom_range(0, NR_KEY - 1), KEY_LEN'($urandom), pool_data(), 1'b0);
        2: if ($urandom_range(0, 3) == 0) do_clr();
        default: search(pool_data(), $urandom_range(0, 2));
      endcase
    end

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
